// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - types and constants for the nibble-serial adder
package nibble_serial_adder_pkg;

`include "nibble_adder_defs.vh"

  localparam int NIB_W = `NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE = `ST_IDLE,
    RUN  = `ST_RUN,
    DONE = `ST_DONE
  } state_t;

endpackage

// File: rtl/nibble_adder_defs.vh
// rtl/nibble_adder_defs.vh - shared nibble width and FSM state encodings
`ifndef NIBBLE_ADDER_DEFS_VH
`define NIBBLE_ADDER_DEFS_VH

`define NIBBLE_W 4
`define ST_IDLE  2'd0
`define ST_RUN   2'd1
`define ST_DONE  2'd2

`endif

// File: rtl/nibble_serial_adder_slice.sv
// rtl/nibble_serial_adder_slice.sv - combinational 4-bit ripple-carry adder slice
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder that feeds one nibble per clock through a 4-bit slice
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum                 : WIDTH-bit registered sum
//   cout                : carry out of the MSB
//   ovf                 : two's-complement overflow
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIB_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_err
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t            state, next_state;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [IDXW-1:0]   idx;
  logic              carry, cout_q, ovf_q;

  logic [NIB_W-1:0]  slice_a, slice_b, slice_s;
  logic              slice_cout;

  assign slice_a = a_q[idx*NIB_W +: NIB_W];
  assign slice_b = b_q[idx*NIB_W +: NIB_W];

  add4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (idx == LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum_q <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_q[idx*NIB_W +: NIB_W] <= slice_s;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q <= slice_cout;
            // Sign of the result comes from the slice output being written this edge.
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_s[NIB_W-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation with out_ready held high; checks latency and single-cycle out_valid.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      check({tag, "_early_valid"}, out_valid, 0);
    end
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    step();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, out_valid, 1);
  endtask

  logic [W:0]   ref_full;
  logic         ref_ovf;
  int           acc_cyc, prev_acc;

  initial begin
    // Reset
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);

    // Directed vectors
    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("posovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result held, new bundle refused until the output handshake
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    a = 16'hAAAA; b = 16'h5555;
    for (int k = 0; k < 4; k++) step();
    check("bp_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_sum", sum, 16'h3333);
      check("bp_cout", cout, 0);
      check("bp_ovf", ovf, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_valid("bp_next");
    check("bp_next_sum", sum, 16'hFFFF);
    check("bp_next_cout", cout, 0);
    check("bp_next_ovf", ovf, 0);
    step();

    // Reset after two RUN cycles
    a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    for (int k = 0; k < 6; k++) begin
      check("mid_rst_no_result", out_valid, 0);
      step();
    end
    run_op("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Back-to-back stream
    in_valid = 1'b1; out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ref_ovf = (a[W-1] == b[W-1]) && (ref_full[W-1] != a[W-1]);
      check("stream_ready", in_ready, 1);
      step();
      acc_cyc = cyc;
      if (i > 0) check("stream_spacing", acc_cyc - prev_acc, 6);
      prev_acc = acc_cyc;
      wait_valid("stream");
      check("stream_sum", sum, ref_full[W-1:0]);
      check("stream_cout", cout, ref_full[W]);
      check("stream_ovf", ovf, ref_ovf);
      step();
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

- Multi-cycle wide adder: accepts WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds them one 4-bit nibble per clock through a single 4-bit ripple slice, carrying the carry between cycles in a register.
- Returns the registered sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits directly upstream of the team's 4-bit adder datapath, sequencing wide operands into it and collecting its S/COUT outputs.

## Interface
- WIDTH, 16: operand/sum width. Must be a multiple of 4 and ≥ 8.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- in_valid  in  1: operand bundle valid.
- in_ready  out  1: block can accept an operand bundle.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- cin  in  1: carry-in into nibble 0.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- sum  out  WIDTH: registered sum.
- cout  out  1: carry out of the MSB.
- ovf  out  1: two's-complement overflow.

## Operation
- NIB = WIDTH/4. FSM states: IDLE, RUN, DONE.
- **IDLE:** in_ready=1.
  - When in_valid & in_ready at an edge: capture a, b and cin (cin into the carry register).
  - Clear sum, set nibble index idx=0, go to RUN.
- **RUN:** in_ready=0. Each edge:
  - Slice adds a[4·idx+:4] + b[4·idx+:4] + carry.
  - Slice S is written to sum[4·idx+:4]; slice COUT is written to the carry register.
  - idx increments.
  - On the edge with idx=NIB-1: go to DONE, set cout = slice COUT, and set ovf = (a_msb==b_msb) & (new sum_msb != a_msb), using the captured operands.
- **DONE:** out_valid=1.
  - sum, cout and ovf are held stable.
  - Go to IDLE on the edge where out_ready=1.
- in_valid outside IDLE is ignored, and operand changes are not sampled.
- Arithmetic is unsigned modulo 2^WIDTH. The carry beyond the MSB appears only on cout. The carry register is 1 bit and idx is ceil(log2(NIB)) bits.
- Reset (rst_n=0 at an edge), in any state including mid-RUN or DONE:
  - state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, carry=0, idx=0.
  - Any in-flight operation is discarded and no result is emitted.

## Timing
- Reset values:
  - in_ready=1 (state IDLE).
  - out_valid=0, sum=0, cout=0, ovf=0.
- in_ready and out_valid are decoded directly from the state register; no combinational path from inputs.
- Latency: input handshake at edge T0 → out_valid=1 in the cycle after edge T0+NIB (NIB cycles).
- Minimum period with out_ready held high: one operation every NIB+2 cycles.
  - Output handshake at T0+NIB+1.
  - in_ready=1 again after that edge.
  - Next accept at T0+NIB+2.
- No same-cycle accept while in DONE: in_ready=0 in DONE even when out_ready=1.
- Backpressure: DONE may last indefinitely. Outputs must not change while out_valid=1 and out_ready=0.
- sum during RUN is partially built. Checkers sample it only when out_valid=1.

## Structure
- Shared include file nibble_adder_defs.vh:
  - NIBBLE_W = 4.
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One sub-module, add4_slice: a combinational 4-bit ripple adder with ports a[3:0], b[3:0], cin, s[3:0], cout.
- The top-level module holds the FSM, operand registers, idx, carry and result registers.
- Width check: WIDTH%4 != 0 triggers a simulation $error at time 0.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge, for one cycle.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 RUN cycles).
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a=0xAAAA, b=0x5555 → sum, cout and ovf stay stable, in_ready=0, and the new bundle is not accepted until after the output handshake.
- Reset mid-operation: drop rst_n for one edge after 2 RUN cycles → next cycle out_valid=0, in_ready=1, sum=0. A subsequent op a=0x0F0F, b=0x0101 gives sum=0x1010.
- Back-to-back stream of 10 random operand pairs with in_valid=1 and out_ready=1 → accepts every 6 cycles, and every result matches a+b+cin against a reference model.
